bcd_stopwatch: RTL
==================

Name: bcd_stopwatch

Overview:
- Consumer of the divided clock. Takes the level output of the clock divider (`new_clk`, one toggle per half-period) on the same `clk`.
- Detects each rising edge of that input and uses it as a count tick. Runs a BCD MM:SS stopwatch with start/stop and clear.
- Drives the seven-segment display driver downstream, with four BCD digits plus status flags.

Parameters:
- TICK_EDGES, 1, number of tick_in rising edges per count increment (1..255); lets the divider run faster than 1 Hz.

Ports:
- clk  input  1  system clock; tick_in is already synchronous to it.
- n_rst  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided-clock level from the clock divider.
- start_stop  input  1  one-cycle pulse; toggles run/pause.
- clear  input  1  one-cycle pulse; zero digits, return to idle.
- sec_ones  output  4  BCD 0-9.
- sec_tens  output  4  BCD 0-5.
- min_ones  output  4  BCD 0-9.
- min_tens  output  4  BCD 0-5.
- running  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse on 59:59 -> 00:00.

Behaviour:
- Reset (n_rst low, asynchronous): all digits 0, state IDLE, running 0, wrap 0, edge counter 0, tick_q 1.
  - tick_q resets to 1 so that tick_in high at reset release is not taken as an edge.
- Edge detect: edge = tick_in & ~tick_q; tick_q <= tick_in every clk.
- Prescale: in RUN, each edge increments edge_cnt. When edge_cnt == TICK_EDGES-1, edge_cnt <= 0 and a count step occurs in the same cycle.
  - edge_cnt holds in PAUSE and is cleared in IDLE.
- Latency: digits change on the first clk edge at which tick_in is sampled 1 after being 0 (TICK_EDGES=1). Outputs are registered, so there is no combinational path from input to output.
- State machine, three states:
  - IDLE: running=0, digits 00:00. start_stop -> RUN.
  - RUN: running=1, counts. start_stop -> PAUSE.
  - PAUSE: running=0, digits hold. start_stop -> RUN.
  - clear in any state -> IDLE, digits 0, edge_cnt 0.
- Priority, same cycle: clear > start_stop > count step.
  - A count step is taken only if the current (pre-edge) state is RUN.
  - So start_stop and a step together in RUN: step counted, then PAUSE.
  - start_stop and a step together in PAUSE: no step, then RUN.
- Count step, BCD carry chain:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - min_tens 5->0 is a full wrap.
  - No digit ever takes a non-BCD value.
- Wrap: at 59:59 a step gives 00:00, wrap=1 for exactly that one cycle, and the state stays RUN.
- wrap is 0 in every other cycle, including after clear.
- Reset asserted mid-count: immediate return to reset values, no partial carry.

Optional Feature:
- Macro: BCD_STOPWATCH_COUNTDOWN_EN.
- When defined:
  - Adds input `count_down` (1 bit), sampled on each count step; when high, the digits decrement with BCD borrow.
  - A decrement from 00:01 reaching 00:00 moves to a fourth state, DONE.
  - Adds output `done` (1 bit), high in DONE.
  - In DONE: running=0, digits held at 00:00, start_stop ignored; only clear or reset leaves DONE, to IDLE.
  - A step in RUN with count_down=1 at 00:00 goes to DONE immediately; it never underflows to 59:59.
  - Add input `load` (1 bit) plus `load_val` (16 bits, four BCD nibbles: min_tens, min_ones, sec_tens, sec_ones). `load` is honoured only in IDLE and loads `load_val` into the digits.
- When not defined: those ports and the DONE state do not exist, and the counter counts up only.

Test Plan:
- Reset with tick_in=1 held, release n_rst, hold tick_in high 10 cycles -> no count, digits 00:00, running=0.
- start_stop pulse, then 5 tick_in rising edges (TICK_EDGES=1) -> sec_ones=5; each digit update occurs on the clk edge where tick_in is first sampled high.
- Preload via 3599 steps in RUN, one more edge -> 00:00, wrap high exactly 1 cycle, running stays 1.
- In RUN, start_stop coincident with an edge at 00:09 -> 00:10 shown, then PAUSE. Further edges hold 00:10. start_stop with an edge -> RUN, that edge not counted.
- clear and start_stop on the same cycle in PAUSE at 12:34 -> IDLE, 00:00, running=0. TICK_EDGES=4: 8 edges in RUN -> 00:02.
- COUNTDOWN_EN: in IDLE, load 00:03 with load_val=0x0003, start, count_down=1, 3 steps -> 00:00 and done=1. start_stop ignored; clear -> IDLE, done=0.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// BCD MM:SS stopwatch counting rising edges of the divided clock level tick_in.
// Optional countdown/load/DONE support is enabled with `define BCD_STOPWATCH_COUNTDOWN_EN.
module bcd_stopwatch #(
    parameter int TICK_EDGES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    input  logic        count_down,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done,
`endif
    output logic [3:0]  sec_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  min_tens,
    output logic        running,
    output logic        wrap
);

    localparam logic [7:0] LAST_EDGE = 8'(TICK_EDGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        ,
        ST_DONE  = 2'd3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       tick_q, tick_d;
    logic [7:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic       running_q, running_d;
    logic       wrap_q, wrap_d;
    logic       edge_det;
    logic       step;

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    logic       done_q, done_d;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction
`endif

    always_comb begin
        tick_d     = tick_in;
        edge_det   = tick_in & ~tick_q;
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        step       = 1'b0;

        // Prescaler: only RUN advances it, PAUSE holds it, IDLE keeps it at zero.
        if (state_q == ST_RUN && edge_det) begin
            if (edge_cnt_q >= LAST_EDGE) begin
                edge_cnt_d = 8'd0;
                step       = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 8'd1;
            end
        end
        if (state_q == ST_IDLE) begin
            edge_cnt_d = 8'd0;
        end

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        if (step && count_down) begin
            if ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'h0000) begin
                state_d = ST_DONE;
            end else begin
                if (sec_ones_q != 4'd0) begin
                    sec_ones_d = sec_ones_q - 4'd1;
                end else begin
                    sec_ones_d = 4'd9;
                    if (sec_tens_q != 4'd0) begin
                        sec_tens_d = sec_tens_q - 4'd1;
                    end else begin
                        sec_tens_d = 4'd5;
                        if (min_ones_q != 4'd0) begin
                            min_ones_d = min_ones_q - 4'd1;
                        end else begin
                            min_ones_d = 4'd9;
                            min_tens_d = min_tens_q - 4'd1;
                        end
                    end
                end
                if ({min_tens_d, min_ones_d, sec_tens_d, sec_ones_d} == 16'h0000) begin
                    state_d = ST_DONE;
                end
            end
        end else
`endif
        if (step) begin
            if (sec_ones_q < 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q < 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q < 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q < 4'd5) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            wrap_d     = 1'b1;
                        end
                    end
                end
            end
        end

        // start_stop acts after the step, so a step landing in DONE is not undone.
        if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   if (state_d == ST_RUN) state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = state_d;
            endcase
        end

`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        if (load && state_q == ST_IDLE) begin
            min_tens_d = clamp_digit(load_val[15:12], 4'd5);
            min_ones_d = clamp_digit(load_val[11:8],  4'd9);
            sec_tens_d = clamp_digit(load_val[7:4],   4'd5);
            sec_ones_d = clamp_digit(load_val[3:0],   4'd9);
        end
`endif

        if (clear) begin
            state_d    = ST_IDLE;
            edge_cnt_d = 8'd0;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
            wrap_d     = 1'b0;
        end

        running_d = (state_d == ST_RUN);
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
        done_d    = (state_d == ST_DONE);
`endif
    end

    // tick_q resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b1;
            edge_cnt_q <= 8'd0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            edge_cnt_q <= edge_cnt_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
            done_q     <= done_d;
`endif
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign running  = running_q;
    assign wrap     = wrap_q;
`ifdef BCD_STOPWATCH_COUNTDOWN_EN
    assign done     = done_q;
`endif

endmodule
